// File: rtl/pe_conv_writer.sv
// Single-MAC sequencer for the 2x2 valid output of a 3x3 filter over a 4x4 image.
// One edge per tap, one store edge per window and one done edge: 42 cycles per run. start is ignored while busy.
module pe_conv_writer #(
   parameter int DATA_W   = 8,
   parameter int SATURATE = 0
) (
   input  logic                 clk,
   input  logic                 rst_pe,
   input  logic                 start,
   input  logic [16*DATA_W-1:0] img_flat,
   input  logic [9*DATA_W-1:0]  fil_flat,
   output logic                 busy,
   output logic                 done,
   output logic [DATA_W-1:0]    PE_result,
   output logic                 C11_PE,
   output logic                 C12_PE,
   output logic                 C21_PE,
   output logic                 C22_PE
);

   localparam int ACC_W = 2*DATA_W + 4;

   typedef enum logic [1:0] {IDLE, MAC, WR, FIN} state_t;

   state_t               state, state_n;
   logic [16*DATA_W-1:0] img_q;
   logic [9*DATA_W-1:0]  fil_q;
   logic [ACC_W-1:0]     acc, acc_n;
   logic [3:0]           k, k_n;
   logic [1:0]           win, win_n;
   logic                 busy_n, done_n, load;
   logic [3:0]           strb, strb_n;
   logic [DATA_W-1:0]    res_n, red;

   logic [1:0]           tap_i, tap_j, row, col;
   logic [3:0]           img_idx;
   logic [DATA_W-1:0]    a_op, b_op;
   logic [2*DATA_W-1:0]  prod;

   // Window origin comes from win: bit 1 selects the row offset, bit 0 the column offset.
   always_comb begin
      tap_i   = 2'(k / 4'd3);
      tap_j   = 2'(k % 4'd3);
      row     = {1'b0, win[1]} + tap_i;
      col     = {1'b0, win[0]} + tap_j;
      img_idx = {row, col};
      a_op    = img_q[DATA_W*img_idx +: DATA_W];
      b_op    = fil_q[DATA_W*k +: DATA_W];
      prod    = {{DATA_W{1'b0}}, a_op} * {{DATA_W{1'b0}}, b_op};
   end

   always_comb begin
      if ((SATURATE != 0) && (acc[ACC_W-1:DATA_W] != '0))
         red = '1;
      else
         red = acc[DATA_W-1:0];
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      k_n     = k;
      win_n   = win;
      busy_n  = busy;
      done_n  = 1'b0;
      strb_n  = 4'b0000;
      res_n   = PE_result;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               acc_n   = '0;
               k_n     = '0;
               win_n   = '0;
               busy_n  = 1'b1;
               state_n = MAC;
            end
         end
         MAC: begin
            acc_n = acc + {4'b0000, prod};
            if (k == 4'd8)
               state_n = WR;
            else
               k_n = k + 4'd1;
         end
         WR: begin
            res_n  = red;
            strb_n = 4'b0001 << win;
            acc_n  = '0;
            k_n    = '0;
            if (win != 2'd3) begin
               win_n   = win + 2'd1;
               state_n = MAC;
            end else begin
               state_n = FIN;
            end
         end
         FIN: begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_pe) begin
      if (rst_pe) begin
         state     <= IDLE;
         img_q     <= '0;
         fil_q     <= '0;
         acc       <= '0;
         k         <= '0;
         win       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         strb      <= 4'b0000;
         PE_result <= '0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         k         <= k_n;
         win       <= win_n;
         busy      <= busy_n;
         done      <= done_n;
         strb      <= strb_n;
         PE_result <= res_n;
         if (load) begin
            img_q <= img_flat;
            fil_q <= fil_flat;
         end
      end
   end

   assign C11_PE = strb[0];
   assign C12_PE = strb[1];
   assign C21_PE = strb[2];
   assign C22_PE = strb[3];

endmodule

// File: tb/tb_pe_conv_writer.sv
// Directed bench: one truncating and one saturating instance share stimulus.
module tb_pe_conv_writer;

   logic         clk = 1'b0;
   logic         rst_pe;
   logic         start;
   logic [127:0] img_flat;
   logic [71:0]  fil_flat;

   logic       busy0, done0, c11_0, c12_0, c21_0, c22_0;
   logic       busy1, done1, c11_1, c12_1, c21_1, c22_1;
   logic [7:0] res0, res1;

   int checks = 0;
   int errors = 0;
   int cur_n  = 0;

   always #5 clk = ~clk;

   pe_conv_writer #(.DATA_W(8), .SATURATE(0)) dut0 (
      .clk(clk), .rst_pe(rst_pe), .start(start),
      .img_flat(img_flat), .fil_flat(fil_flat),
      .busy(busy0), .done(done0), .PE_result(res0),
      .C11_PE(c11_0), .C12_PE(c12_0), .C21_PE(c21_0), .C22_PE(c22_0)
   );

   pe_conv_writer #(.DATA_W(8), .SATURATE(1)) dut1 (
      .clk(clk), .rst_pe(rst_pe), .start(start),
      .img_flat(img_flat), .fil_flat(fil_flat),
      .busy(busy1), .done(done1), .PE_result(res1),
      .C11_PE(c11_1), .C12_PE(c12_1), .C21_PE(c21_1), .C22_PE(c22_1)
   );

   typedef struct {
      logic [127:0] img;
      logic [71:0]  fil;
      logic [31:0]  e0;   // truncated results, window w at [8*w +: 8]
      logic [31:0]  e1;   // saturated results
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cur_n, act, exp);
      end
   endtask

   function automatic logic [5:0] exp_st(input int n, input bit hold);
      int m;
      if (!hold && n >= 42) return 6'b0;
      m = n % 42;
      return {m <= 40, m == 41, m == 40, m == 30, m == 20, m == 10};
   endfunction

   function automatic logic [11:0] act_st();
      return {busy0, done0, c22_0, c21_0, c12_0, c11_0,
              busy1, done1, c22_1, c21_1, c12_1, c11_1};
   endfunction

   // mode: 0 plain pulse, 1 stray start pulses at E5/E41, 2 image zeroed at E3, 3 start held for two runs
   task automatic run(input vec_t v, input int mode);
      int last;
      int m;
      logic [5:0] e;
      last = (mode == 3) ? 83 : 44;
      @(negedge clk);
      img_flat = v.img;
      fil_flat = v.fil;
      start    = 1'b1;
      for (int n = 0; n <= last; n++) begin
         @(posedge clk);
         @(negedge clk);
         cur_n = n;
         e = exp_st(n, mode == 3);
         chk("status", 64'(act_st()), 64'({e, e}));
         m = n % 42;
         if (m == 10 || m == 20 || m == 30 || m == 40)
            chk("result", 64'({res0, res1}), 64'({v.e0[8*(m/10-1) +: 8], v.e1[8*(m/10-1) +: 8]}));
         if (m == 41 || n == 42 || n == 44)
            chk("result_hold", 64'({res0, res1}), 64'({v.e0[31:24], v.e1[31:24]}));
         start = ((mode == 3) && (n < 83)) || ((mode == 1) && ((n + 1 == 5) || (n + 1 == 41)));
         if ((mode == 2) && (n + 1 == 3)) img_flat = '0;
      end
      start = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 16; r++) vecs[0].img[8*r +: 8] = 8'(r + 1);
      for (int t = 0; t < 9; t++)  vecs[0].fil[8*t +: 8] = 8'(t + 1);
      vecs[0].e0 = {8'd61, 8'd16, 8'd137, 8'd92};
      vecs[0].e1 = {8'd255, 8'd255, 8'd255, 8'd255};

      vecs[1].img = vecs[0].img;
      vecs[1].fil = '0;
      vecs[1].fil[39:32] = 8'd1;
      vecs[1].e0 = {8'd11, 8'd10, 8'd7, 8'd6};
      vecs[1].e1 = {8'd11, 8'd10, 8'd7, 8'd6};

      vecs[2].img = '1;
      vecs[2].fil = '1;
      vecs[2].e0 = {8'd9, 8'd9, 8'd9, 8'd9};
      vecs[2].e1 = {8'd255, 8'd255, 8'd255, 8'd255};

      vecs[3].img = vecs[0].img;
      vecs[3].fil = '0;
      vecs[3].e0 = '0;
      vecs[3].e1 = '0;

      rst_pe   = 1'b1;
      start    = 1'b0;
      img_flat = '0;
      fil_flat = '0;
      #12;
      chk("reset_state", 64'({act_st(), res0, res1}), 64'(0));
      @(negedge clk);
      rst_pe = 1'b0;

      for (int i = 0; i < 4; i++) run(vecs[i], 0);
      run(vecs[0], 1);
      run(vecs[0], 3);
      run(vecs[0], 2);

      // Mid-run reset at E15, after the first result has been stored.
      @(negedge clk);
      img_flat = vecs[0].img;
      fil_flat = vecs[0].fil;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1 rst_pe = 1'b1;
      #1;
      cur_n = 15;
      chk("async_reset", 64'({act_st(), res0, res1}), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_pe = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         cur_n = 100 + n;
         chk("after_reset", 64'({act_st(), res0, res1}), 64'(0));
      end
      run(vecs[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_conv_writer.md
Name: pe_conv_writer

Overview:
- Single-PE convolution sequencer. It computes the 2×2 valid output of a 3×3 filter slid over a 4×4 image, using one multiply-accumulate unit.
- It is the writer side of the memory result interface: it presents PE_result with the one-hot store strobes C11_PE, C12_PE, C21_PE and C22_PE.
- Image and filter operands come from the memory's a11..a44 and b11..b33 outputs, packed at top level into two flat buses.

Parameters:
- DATA_W, 8, operand and result width.
- SATURATE, 0, selects the result reduction: 0 = keep the low DATA_W bits of the accumulator (mod 2^DATA_W); 1 = clamp to 2^DATA_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_pe  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- img_flat  in  16*DATA_W  image; a_rc = img_flat[DATA_W*(4*(r-1)+(c-1)) +: DATA_W], r,c = 1..4.
- fil_flat  in  9*DATA_W  filter; b_ij = fil_flat[DATA_W*(3*(i-1)+(j-1)) +: DATA_W], i,j = 1..3.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- PE_result  out  DATA_W  registered result; holds its value between strobes.
- C11_PE  out  1  store strobe, output (1,1).
- C12_PE  out  1  store strobe, output (1,2).
- C21_PE  out  1  store strobe, output (2,1).
- C22_PE  out  1  store strobe, output (2,2).

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, all strobes = 0; PE_result = 0; accumulator, tap counter and window index = 0. Reset mid-run aborts with no further strobes.
- States:
  - IDLE: start=1 at edge E0 → snapshot img_flat/fil_flat into internal registers, acc=0, k=0, win=0, busy=1, state=MAC.
  - MAC: each edge does acc += b(i,j)*a(r0+i-1, c0+j-1) for tap k=0..8, taps in filter row-major order. On the edge completing k=8 → state=WR.
  - WR (one edge): PE_result <= reduce(acc); assert the strobe for win (0=C11, 1=C12, 2=C21, 3=C22); acc=0, k=0. If win<3: win++ and state=MAC. Else state=FIN.
  - FIN (one edge): strobes=0, busy=0, done=1 for this cycle only, state=IDLE.
- Window origins (r0,c0): C11=(1,1), C12=(1,2), C21=(2,1), C22=(2,2).
- Timing from E0: MAC edges E1-E9, strobe C11 set at E10, C12 at E20, C21 at E30, C22 at E40. done is set at E41 and cleared at E42.
- Each strobe is high for exactly one cycle and is cleared at the next edge. Strobes are mutually exclusive. PE_result is stable throughout a strobe cycle.
- Arithmetic:
  - Products are unsigned 2*DATA_W bits.
  - The accumulator is 2*DATA_W+4 bits (20 for DATA_W=8) and never overflows.
  - reduce() truncates when SATURATE=0; when SATURATE=1 it outputs 2^DATA_W-1 if acc ≥ 2^DATA_W, else acc.
- start while busy (states MAC, WR, FIN) is ignored. start held high re-triggers a new run at E42, the first IDLE edge.
- Operand inputs changing during a run do not affect the result because the snapshot is used.
- Throughput: 42 cycles per run, including FIN and the IDLE sampling edge.

Test Plan:
- Image 1..16 row-major, filter 1..9, SATURATE=0, start pulse at E0 → PE_result 92 with C11_PE at E10, 137/C12 at E20, 16/C21 at E30, 61/C22 at E40. done pulses at E41; busy is high from E0 until E41.
- Same operands with SATURATE=1 → all four results = 255 (raw 348, 393, 528, 573).
- Image 1..16, filter with b22=1 and all other taps 0 → results 6, 7, 10, 11. All operands 255 → SATURATE=0 gives 9 per window; SATURATE=1 gives 255.
- start pulses at E5 and E41, and start held high → no effect mid-run; start held high gives a second C11 strobe at E52 and done at E83.
- rst_pe asserted at E15 for 2 cycles → all outputs 0 immediately, including the async-cleared PE_result; no strobes follow. A later start produces the full 92/137/16/61 sequence.
- Change img_flat to all zeros at E3 → results are still 92/137/16/61, because the snapshot is used.
